// File: rtl/item_pkg.sv
// Shared types and constants for the six-slot item inventory.
package item_pkg;

  localparam int NUM_SLOTS = 6;
  localparam int NUM_TYPES = 7;

  // One inventory slot: valid flag plus item kind (0..6 legal).
  typedef struct packed {
    logic       valid;
    logic [2:0] kind;
  } item_t;

  // Deal sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAL = 2'd1,
    ST_DONE = 2'd2
  } deal_state_t;

  // Number of set bits in a slot-valid vector.
  function automatic logic [2:0] count_valid(input logic [NUM_SLOTS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/item_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR that supplies candidate item types.
module item_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [15:0] o_value
);

  logic [15:0] r_lfsr;

  // Advance every cycle; taps 16,14,13,11 give a maximal-length sequence.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/item_inventory.sv
// Six-slot player inventory: deals random items into empty slots one per
// cycle and removes items on use requests.
module item_inventory
  import item_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_deal_start,
  input  logic [2:0] i_deal_count,
  input  logic       i_use,
  input  logic [2:0] i_use_slot,
  input  logic       i_clear,
  output logic [3:0] o_item0,
  output logic [3:0] o_item1,
  output logic [3:0] o_item2,
  output logic [3:0] o_item3,
  output logic [3:0] o_item4,
  output logic [3:0] o_item5,
  output logic [2:0] o_occupied,
  output logic       o_busy,
  output logic       o_done,
  output logic [2:0] o_dealt,
  output logic       o_used_valid,
  output logic [2:0] o_used_type,
  output logic       o_use_err
);

  logic [15:0]          w_lfsr;
  logic [2:0]           w_cand;
  logic                 w_cand_ok;
  logic                 w_unused_lfsr_hi;
  deal_state_t          r_state, w_state_next;
  item_t                r_slots [NUM_SLOTS];
  item_t                w_slots_next [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] w_empty;
  logic [NUM_SLOTS-1:0] w_valid_next;
  logic                 w_have_empty;
  logic [2:0]           w_fill_idx;
  item_t                w_use_item;
  logic [2:0]           w_count_clamped;
  logic [2:0]           r_remaining, w_remaining_next;
  logic [2:0]           r_placed, w_placed_next;
  logic [2:0]           r_occupied;
  logic                 r_done, w_done_next;
  logic [2:0]           r_dealt, w_dealt_next;
  logic                 r_used_valid, w_used_valid_next;
  logic [2:0]           r_used_type, w_used_type_next;
  logic                 r_use_err, w_use_err_next;

  item_lfsr16 #(.SEED(SEED)) u_lfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .o_value (w_lfsr)
  );

  // Only the low three bits form a candidate; type 7 means reroll.
  assign w_cand           = w_lfsr[2:0];
  assign w_cand_ok        = int'(w_cand) < NUM_TYPES;
  assign w_unused_lfsr_hi = ^w_lfsr[15:3];
  assign w_count_clamped  = (i_deal_count > 3'd6) ? 3'd6 : i_deal_count;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot_flags
      assign w_empty[gi]      = ~r_slots[gi].valid;
      assign w_valid_next[gi] = w_slots_next[gi].valid;
    end
  endgenerate

  // Priority encoder: lowest-index empty slot receives the next item.
  always_comb begin
    w_have_empty = |w_empty;
    w_fill_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_empty[i]) w_fill_idx = 3'(i);
    end
  end

  // Select the slot named by a use request; indices 6/7 read as empty.
  always_comb begin
    w_use_item = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (i_use_slot == 3'(i)) w_use_item = r_slots[i];
    end
  end

  // Next-state and datapath decisions; clear overrides everything else.
  always_comb begin
    w_state_next      = r_state;
    w_slots_next      = r_slots;
    w_remaining_next  = r_remaining;
    w_placed_next     = r_placed;
    w_done_next       = 1'b0;
    w_dealt_next      = r_dealt;
    w_used_valid_next = 1'b0;
    w_used_type_next  = r_used_type;
    w_use_err_next    = 1'b0;
    if (i_clear) begin
      for (int i = 0; i < NUM_SLOTS; i++) w_slots_next[i] = '0;
      w_state_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          // Use is applied before a same-cycle deal start takes effect.
          if (i_use) begin
            if (w_use_item.valid) begin
              for (int i = 0; i < NUM_SLOTS; i++) begin
                if (i_use_slot == 3'(i)) w_slots_next[i] = '0;
              end
              w_used_valid_next = 1'b1;
              w_used_type_next  = w_use_item.kind;
            end else begin
              w_use_err_next = 1'b1;
            end
          end
          if (i_deal_start) begin
            w_remaining_next = w_count_clamped;
            w_placed_next    = '0;
            w_state_next     = (w_count_clamped == 3'd0) ? ST_DONE : ST_DEAL;
          end
        end
        ST_DEAL: begin
          w_use_err_next = i_use;
          if (!w_have_empty) begin
            w_state_next = ST_DONE;
          end else if (w_cand_ok) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (w_fill_idx == 3'(i)) w_slots_next[i] = {1'b1, w_cand};
            end
            w_remaining_next = r_remaining - 3'd1;
            w_placed_next    = r_placed + 3'd1;
            if (r_remaining == 3'd1) w_state_next = ST_DONE;
          end
        end
        ST_DONE: begin
          w_use_err_next = i_use;
          w_done_next    = 1'b1;
          w_dealt_next   = r_placed;
          w_state_next   = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Slot storage, counters and registered status outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) r_slots[i] <= '0;
      r_remaining  <= '0;
      r_placed     <= '0;
      r_occupied   <= '0;
      r_done       <= 1'b0;
      r_dealt      <= '0;
      r_used_valid <= 1'b0;
      r_used_type  <= '0;
      r_use_err    <= 1'b0;
    end else begin
      r_slots      <= w_slots_next;
      r_remaining  <= w_remaining_next;
      r_placed     <= w_placed_next;
      r_occupied   <= count_valid(w_valid_next);
      r_done       <= w_done_next;
      r_dealt      <= w_dealt_next;
      r_used_valid <= w_used_valid_next;
      r_used_type  <= w_used_type_next;
      r_use_err    <= w_use_err_next;
    end
  end

  assign o_item0      = r_slots[0];
  assign o_item1      = r_slots[1];
  assign o_item2      = r_slots[2];
  assign o_item3      = r_slots[3];
  assign o_item4      = r_slots[4];
  assign o_item5      = r_slots[5];
  assign o_occupied   = r_occupied;
  assign o_busy       = (r_state == ST_DEAL);
  assign o_done       = r_done;
  assign o_dealt      = r_dealt;
  assign o_used_valid = r_used_valid;
  assign o_used_type  = r_used_type;
  assign o_use_err    = r_use_err;

endmodule

// File: tb/tb_item_inventory.sv
// Scoreboard bench for item_inventory: stimulus pushes expected use/deal
// results, a monitor pops and compares whenever the DUT pulses a result.
module tb_item_inventory;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_deal_start;
  logic [2:0] i_deal_count;
  logic       i_use;
  logic [2:0] i_use_slot;
  logic       i_clear;
  logic [3:0] o_item0, o_item1, o_item2, o_item3, o_item4, o_item5;
  logic [2:0] o_occupied;
  logic       o_busy;
  logic       o_done;
  logic [2:0] o_dealt;
  logic       o_used_valid;
  logic [2:0] o_used_type;
  logic       o_use_err;
  logic [3:0] w_items [6];

  always #5 clk = ~clk;

  item_inventory #(.SEED(16'hACE1)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_deal_start (i_deal_start),
    .i_deal_count (i_deal_count),
    .i_use        (i_use),
    .i_use_slot   (i_use_slot),
    .i_clear      (i_clear),
    .o_item0      (o_item0),
    .o_item1      (o_item1),
    .o_item2      (o_item2),
    .o_item3      (o_item3),
    .o_item4      (o_item4),
    .o_item5      (o_item5),
    .o_occupied   (o_occupied),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_dealt      (o_dealt),
    .o_used_valid (o_used_valid),
    .o_used_type  (o_used_type),
    .o_use_err    (o_use_err)
  );

  assign w_items[0] = o_item0;
  assign w_items[1] = o_item1;
  assign w_items[2] = o_item2;
  assign w_items[3] = o_item3;
  assign w_items[4] = o_item4;
  assign w_items[5] = o_item5;

  typedef struct packed {
    logic       ok;
    logic [2:0] typ;
    logic [2:0] slot;
  } use_rec_t;

  typedef struct packed {
    logic [2:0]  dealt;
    logic [2:0]  occ;
    logic [23:0] items;
  } done_rec_t;

  use_rec_t   uq[$];
  done_rec_t  dq[$];
  logic [3:0] exp_slots [6];
  logic [15:0] m_lfsr;
  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Golden LFSR, free-running from the same seed.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) m_lfsr <= 16'hACE1;
    else       m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  function automatic logic [2:0] exp_occ();
    logic [2:0] n;
    n = '0;
    for (int s = 0; s < 6; s++) n = n + {2'b00, exp_slots[s][3]};
    return n;
  endfunction

  function automatic void clear_exp();
    for (int s = 0; s < 6; s++) exp_slots[s] = 4'h0;
  endfunction

  // Predict a deal starting from the current LFSR value; push its result.
  task automatic predict(input int count, output int cycles);
    int rem, placed, idx;
    logic [15:0] v;
    done_rec_t r;
    rem    = (count > 6) ? 6 : count;
    v      = m_lfsr;
    placed = 0;
    cycles = 0;
    while (rem > 0) begin
      cycles++;
      v   = lfsr_step(v);
      idx = -1;
      for (int s = 5; s >= 0; s--) if (!exp_slots[s][3]) idx = s;
      if (idx < 0) break;
      if (v[2:0] != 3'd7) begin
        exp_slots[idx] = {1'b1, v[2:0]};
        rem--;
        placed++;
      end
    end
    r.dealt = 3'(placed);
    r.occ   = exp_occ();
    for (int s = 0; s < 6; s++) r.items[4*s +: 4] = exp_slots[s];
    dq.push_back(r);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (o_done) seen = 1;
      else @(negedge clk);
    end
    if (!seen) chk("done_timeout", 32'(o_done), 32'd1);
  endtask

  // Called at a negedge in IDLE; returns at the negedge showing o_done.
  task automatic do_deal(input int count);
    int cyc, cnt;
    bit seen;
    i_deal_start = 1'b1;
    i_deal_count = 3'(count);
    predict(count, cyc);
    seen = 0;
    cnt  = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      i_deal_start = 1'b0;
      if (cnt == 1) chk("busy_after_start", 32'(o_busy), 32'(count != 0));
      if (o_done) seen = 1;
    end
    if (!seen) chk("done_timeout", 32'(o_done), 32'd1);
    else       chk("deal_cycles", 32'(cnt), 32'(cyc + 2));
  endtask

  task automatic do_use(input int slot);
    use_rec_t r;
    i_use      = 1'b1;
    i_use_slot = 3'(slot);
    r.ok   = (slot <= 5) ? exp_slots[slot][3] : 1'b0;
    r.typ  = r.ok ? exp_slots[slot][2:0] : 3'd0;
    r.slot = r.ok ? 3'(slot) : 3'd0;
    if (r.ok) exp_slots[slot] = 4'h0;
    uq.push_back(r);
    @(negedge clk);
    i_use = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int s = 0; s < 6; s++) chk({tag, "_item"}, 32'(w_items[s]), 32'd0);
    chk({tag, "_occupied"}, 32'(o_occupied), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  task automatic wait_two_placed();
    bit seen;
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (o_occupied == 3'd2) seen = 1;
      else @(negedge clk);
    end
    chk("reach_two_placed", 32'(o_occupied), 32'd2);
  endtask

  // Monitor: compare every result pulse against the scoreboard.
  initial begin
    use_rec_t  ur;
    done_rec_t dr;
    forever begin
      @(negedge clk);
      if (!i_rst) begin
        if (o_used_valid || o_use_err) begin
          if (uq.size() == 0) begin
            chk("unexpected_use_pulse", 32'({o_used_valid, o_use_err}), 32'd0);
          end else begin
            ur = uq.pop_front();
            if (ur.ok) begin
              chk("use_valid", 32'(o_used_valid), 32'd1);
              chk("use_type", 32'(o_used_type), 32'(ur.typ));
              chk("use_slot_cleared", 32'(w_items[ur.slot]), 32'd0);
            end else begin
              chk("use_err", 32'(o_use_err), 32'd1);
            end
          end
        end
        if (o_done) begin
          if (dq.size() == 0) begin
            chk("unexpected_done", 32'(o_done), 32'd0);
          end else begin
            dr = dq.pop_front();
            chk("done_dealt", 32'(o_dealt), 32'(dr.dealt));
            chk("done_occupied", 32'(o_occupied), 32'(dr.occ));
            for (int s = 0; s < 6; s++)
              chk("done_item", 32'(w_items[s]), 32'(dr.items[4*s +: 4]));
          end
        end
      end
    end
  end

  initial begin
    use_rec_t r;
    int cyc;
    i_rst = 1'b1; i_deal_start = 1'b0; i_deal_count = 3'd0;
    i_use = 1'b0; i_use_slot = 3'd0; i_clear = 1'b0;
    clear_exp();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_done", 32'(o_done), 32'd0);
    chk("reset_dealt", 32'(o_dealt), 32'd0);
    chk("reset_used", 32'({o_used_valid, o_used_type, o_use_err}), 32'd0);
    i_rst = 1'b0;
    @(negedge clk);

    // Basic deal of 3 from empty.
    do_deal(3);
    chk("basic_dealt", 32'(o_dealt), 32'd3);

    // Accept, then reject the same slot, then reject an out-of-range slot.
    do_use(1);
    do_use(1);
    do_use(6);

    // Refill to five full, then early stop with one free slot.
    do_deal(3);
    do_deal(4);
    chk("early_dealt", 32'(o_dealt), 32'd1);
    chk("early_occupied", 32'(o_occupied), 32'd6);

    // Use and deal start together on a full inventory; use again mid-deal.
    i_use = 1'b1; i_use_slot = 3'd2; i_deal_start = 1'b1; i_deal_count = 3'd1;
    r.ok = 1'b1; r.typ = exp_slots[2][2:0]; r.slot = 3'd2;
    uq.push_back(r);
    exp_slots[2] = 4'h0;
    predict(1, cyc);
    @(negedge clk);
    i_deal_start = 1'b0; i_use_slot = 3'd0;
    chk("busy_in_deal", 32'(o_busy), 32'd1);
    r.ok = 1'b0; r.typ = 3'd0; r.slot = 3'd0;
    uq.push_back(r);
    @(negedge clk);
    i_use = 1'b0;
    wait_done();
    chk("refill_dealt", 32'(o_dealt), 32'd1);

    // Zero-count deal finishes without entering DEAL.
    do_deal(0);
    chk("zero_dealt", 32'(o_dealt), 32'd0);

    // Plain clear, then a count of 7 behaves as 6.
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    clear_exp();
    chk_all_zero("clear");
    do_deal(7);
    chk("clamp_dealt", 32'(o_dealt), 32'd6);

    // Clear during DEAL with two items remaining, same-cycle use ignored.
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    clear_exp();
    i_deal_start = 1'b1; i_deal_count = 3'd4;
    @(negedge clk);
    i_deal_start = 1'b0;
    wait_two_placed();
    i_clear = 1'b1; i_use = 1'b1; i_use_slot = 3'd0;
    @(negedge clk);
    i_clear = 1'b0; i_use = 1'b0;
    chk_all_zero("abort");
    chk("abort_no_err", 32'(o_use_err), 32'd0);
    chk("abort_dealt_kept", 32'(o_dealt), 32'd6);
    repeat (4) @(negedge clk);
    chk("abort_no_done", 32'(o_done), 32'd0);

    // Asynchronous reset in the middle of a deal.
    i_deal_start = 1'b1; i_deal_count = 3'd4;
    @(negedge clk);
    i_deal_start = 1'b0;
    wait_two_placed();
    i_rst = 1'b1;
    #1;
    chk_all_zero("midreset");
    chk("midreset_done", 32'(o_done), 32'd0);
    chk("midreset_dealt", 32'(o_dealt), 32'd0);
    clear_exp();
    @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    do_deal(1);
    chk("post_reset_occupied", 32'(o_occupied), 32'd1);

    repeat (5) @(negedge clk);
    chk("use_queue_drained", 32'(uq.size()), 32'd0);
    chk("done_queue_drained", 32'(dq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
